// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: write/read requests, control and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              WrEn;
  logic [DATA_W-1:0] WrData;
  logic              RdEn;
  logic [DATA_W-1:0] RdData;
  logic              RdValid;
  logic              Flush;
  logic              ClrErr;
  logic [LVL_W-1:0]  Level;
  logic              Full;
  logic              AlmostFull;
  logic              Empty;
  logic              AlmostEmpty;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output WrEn, WrData, RdEn, Flush, ClrErr,
    input  RdData, RdValid, Level, Full, AlmostFull, Empty, AlmostEmpty,
           Overflow, Underflow
  );

  modport slave (
    input  WrEn, WrData, RdEn, Flush, ClrErr,
    output RdData, RdValid, Level, Full, AlmostFull, Empty, AlmostEmpty,
           Overflow, Underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read data, fill level,
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 5,
  parameter int AE_THRESH = 1
) (
  input logic              Clk,
  input logic              nReset,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic empty, full, rd_acc, wr_acc;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LVL_FULL);
  // Flush masks both requests so nothing moves and no error is recorded.
  assign rd_acc = bus.RdEn & ~empty & ~bus.Flush;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc = bus.WrEn & (~full | rd_acc) & ~bus.Flush;

  // Next-state: pointers, level, read data and sticky error flags.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (bus.Flush) begin
      // Read data and error flags deliberately survive a flush.
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rptr_d     = rptr_q + PTR_ONE;
        rd_data_d  = mem_q[rptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      // Clear first so a same-cycle set condition wins.
      if (bus.ClrErr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (bus.WrEn & ~wr_acc) begin
        ovf_d = 1'b1;
      end
      if (bus.RdEn & ~rd_acc) begin
        udf_d = 1'b1;
      end
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= bus.WrData;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.RdData      = rd_data_q;
  assign bus.RdValid     = rd_valid_q;
  assign bus.Level       = level_q;
  assign bus.Full        = full;
  assign bus.AlmostFull  = (level_q >= LVL_AF);
  assign bus.Empty       = empty;
  assign bus.AlmostEmpty = (level_q <= LVL_AE);
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = udf_q;
endmodule
